// File: rtl/elbeth_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and the memory.
//   imem_req    : request valid (master -> slave)
//   imem_addr   : word-aligned request address (master -> slave)
//   imem_gnt    : request accepted this cycle (slave -> master)
//   imem_rvalid : response valid, earliest one cycle after grant (slave -> master)
//   imem_rdata  : response instruction (slave -> master)
//   imem_err    : bus error, qualified by imem_rvalid (slave -> master)
interface elbeth_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata, imem_err
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata, imem_err
  );
endinterface

// File: rtl/elbeth_fetch_unit.sv
// Instruction fetch stage. Turns the current PC into one instruction-memory transaction at a
// time and presents the fetched instruction, its PC and exception flags to decode.
//   clk, rst          : clock, asynchronous active-high reset
//   pc                : current PC from the PC register
//   flush             : redirect/kill from the pipeline controller
//   id_stall          : decode cannot accept the instruction this cycle
//   imem              : instruction-memory bus (master side)
//   fetch_stall       : combinational hold for the PC register
//   if_valid          : registered, if_instr/if_pc hold a valid instruction
//   if_instr, if_pc   : registered instruction (NOP when invalid/exception) and its PC
//   if_exc_fault      : registered, fetch returned a bus error
//   if_exc_misaligned : registered, PC was not word-aligned
module elbeth_fetch_unit (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                pc,
  input  logic                       flush,
  input  logic                       id_stall,
  elbeth_fetch_unit_if.master        imem,
  output logic                       fetch_stall,
  output logic                       if_valid,
  output logic [31:0]                if_instr,
  output logic [31:0]                if_pc,
  output logic                       if_exc_fault,
  output logic                       if_exc_misaligned
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StDrain} state_e;

  state_e      state_q, state_d;
  logic [31:0] pend_pc_q;
  logic        valid_q, fault_q, mis_q;
  logic [31:0] instr_q, ipc_q;
  logic        pc_aligned;
  logic        load_mis, load_rsp;

  assign pc_aligned = (pc[1:0] == 2'b00);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; flush takes priority in every state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!flush) state_d = StReq;
      end
      StReq: begin
        if (flush) begin
          // A request granted in the flush cycle is in flight and must be drained
          state_d = (imem.imem_req && imem.imem_gnt) ? StDrain : StReq;
        end else if (!pc_aligned) begin
          state_d = id_stall ? StHold : StReq;
        end else if (imem.imem_gnt) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (imem.imem_rvalid) begin
          state_d = (flush || !id_stall) ? StReq : StHold;
        end else if (flush) begin
          state_d = StDrain;
        end
      end
      StHold: begin
        if (!flush && !id_stall) state_d = StReq;
      end
      StDrain: begin
        if (imem.imem_rvalid) state_d = StReq;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs and load strobes
  always_comb begin
    imem.imem_req  = 1'b0;
    imem.imem_addr = 32'h0;
    fetch_stall    = 1'b1;
    load_mis       = 1'b0;
    load_rsp       = 1'b0;
    unique case (state_q)
      StReq: begin
        if (pc_aligned) begin
          imem.imem_req  = 1'b1;
          imem.imem_addr = pc;
        end else begin
          fetch_stall = id_stall;
          load_mis    = 1'b1;
        end
      end
      StWait: begin
        fetch_stall = !(imem.imem_rvalid && !id_stall);
        load_rsp    = imem.imem_rvalid;
      end
      StHold: begin
        fetch_stall = id_stall;
      end
      default: begin
      end
    endcase
    // Let the PC register take the redirect target
    if (flush) fetch_stall = 1'b0;
  end

  // Pending PC and decode-facing output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_pc_q <= 32'h0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      mis_q     <= 1'b0;
      instr_q   <= Nop;
      ipc_q     <= 32'h0;
    end else begin
      if (imem.imem_req && imem.imem_gnt) pend_pc_q <= pc;
      if (flush) begin
        valid_q <= 1'b0;
        fault_q <= 1'b0;
        mis_q   <= 1'b0;
        instr_q <= Nop;
      end else if (load_mis) begin
        valid_q <= 1'b1;
        fault_q <= 1'b0;
        mis_q   <= 1'b1;
        instr_q <= Nop;
        ipc_q   <= pc;
      end else if (load_rsp) begin
        valid_q <= 1'b1;
        fault_q <= imem.imem_err;
        mis_q   <= 1'b0;
        instr_q <= imem.imem_err ? Nop : imem.imem_rdata;
        ipc_q   <= pend_pc_q;
      end else if (valid_q && !id_stall) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign if_valid          = valid_q;
  assign if_instr          = instr_q;
  assign if_pc             = ipc_q;
  assign if_exc_fault      = fault_q;
  assign if_exc_misaligned = mis_q;

endmodule

// File: tb/tb_elbeth_fetch_unit.sv
module tb_elbeth_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        flush, id_stall;
  logic        fetch_stall, if_valid, if_exc_fault, if_exc_misaligned;
  logic [31:0] if_instr, if_pc;

  elbeth_fetch_unit_if imem_bus ();

  elbeth_fetch_unit dut (
    .clk               (clk),
    .rst               (rst),
    .pc                (pc),
    .flush             (flush),
    .id_stall          (id_stall),
    .imem              (imem_bus),
    .fetch_stall       (fetch_stall),
    .if_valid          (if_valid),
    .if_instr          (if_instr),
    .if_pc             (if_pc),
    .if_exc_fault      (if_exc_fault),
    .if_exc_misaligned (if_exc_misaligned)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // ctl = {flush, id_stall, gnt, rvalid, err}; ec = {req, fetch_stall, if_valid};
  // ef = {fault, misaligned}. Registered fields are checked only when if_valid is expected.
  typedef struct {
    logic [31:0] pc;
    logic [4:0]  ctl;
    logic [31:0] rd;
    logic [2:0]  ec;
    logic [31:0] ea;
    logic [31:0] ei;
    logic [31:0] ep;
    logic [1:0]  ef;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [31:0] p, input logic [4:0] c, input logic [31:0] r,
                              input logic [2:0] e, input logic [31:0] a, input logic [31:0] i,
                              input logic [31:0] q, input logic [1:0] f);
    vec_t v;
    v.pc = p; v.ctl = c; v.rd = r; v.ec = e; v.ea = a; v.ei = i; v.ep = q; v.ef = f;
    vecs.push_back(v);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0135_7ace;
  endfunction

  task automatic drive_idle();
    flush = 1'b0; id_stall = 1'b0;
    imem_bus.imem_gnt = 1'b0; imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata = 32'h0; imem_bus.imem_err = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk1({tag, "_req"}, imem_bus.imem_req, 1'b0);
    chk32({tag, "_addr"}, imem_bus.imem_addr, 32'h0);
    chk1({tag, "_fstall"}, fetch_stall, 1'b1);
    chk1({tag, "_valid"}, if_valid, 1'b0);
    chk32({tag, "_instr"}, if_instr, NOP);
    chk32({tag, "_pc"}, if_pc, 32'h0);
    chk1({tag, "_fault"}, if_exc_fault, 1'b0);
    chk1({tag, "_mis"}, if_exc_misaligned, 1'b0);
  endtask

  // Random-phase model state
  logic [31:0] pc_reg, ob_addr, sl_pc, sl_instr, chain_pc, pend_addr, ipc_s, addr_s;
  logic        ob_busy, ob_live, sl_v, sl_flt, chain_v, pend_chk, req_s, fs_s, rv;
  int          ob_dly;
  int          consumed;

  initial begin
    rst = 1'b1; pc = 32'h200; drive_idle();
    #1;
    chk_reset_vals("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed table, one row per cycle, starting in IDLE
    add(32'h200, 5'b00000, 32'h0,         3'b010, 32'h0,   NOP,           32'h0,   2'b00);
    add(32'h200, 5'b00100, 32'h0,         3'b110, 32'h200, NOP,           32'h0,   2'b00);
    add(32'h200, 5'b00010, 32'h0050_0093, 3'b000, 32'h0,   NOP,           32'h0,   2'b00);
    add(32'h204, 5'b00100, 32'h0,         3'b111, 32'h204, 32'h0050_0093, 32'h200, 2'b00);
    add(32'h204, 5'b00011, 32'h1234_5678, 3'b000, 32'h0,   NOP,           32'h0,   2'b00);
    add(32'h208, 5'b00000, 32'h0,         3'b111, 32'h208, NOP,           32'h204, 2'b10);
    add(32'h208, 5'b00000, 32'h0,         3'b110, 32'h208, NOP,           32'h0,   2'b00);
    add(32'h208, 5'b00000, 32'h0,         3'b110, 32'h208, NOP,           32'h0,   2'b00);
    add(32'h208, 5'b00100, 32'h0,         3'b110, 32'h208, NOP,           32'h0,   2'b00);
    add(32'h208, 5'b01010, 32'h00a0_0113, 3'b010, 32'h0,   NOP,           32'h0,   2'b00);
    add(32'h208, 5'b01000, 32'h0,         3'b011, 32'h0,   32'h00a0_0113, 32'h208, 2'b00);
    add(32'h208, 5'b01000, 32'h0,         3'b011, 32'h0,   32'h00a0_0113, 32'h208, 2'b00);
    add(32'h208, 5'b01000, 32'h0,         3'b011, 32'h0,   32'h00a0_0113, 32'h208, 2'b00);
    add(32'h208, 5'b00000, 32'h0,         3'b001, 32'h0,   32'h00a0_0113, 32'h208, 2'b00);
    add(32'h202, 5'b00000, 32'h0,         3'b000, 32'h0,   NOP,           32'h0,   2'b00);
    add(32'h20c, 5'b01000, 32'h0,         3'b111, 32'h20c, NOP,           32'h202, 2'b01);
    add(32'h20c, 5'b00000, 32'h0,         3'b111, 32'h20c, NOP,           32'h202, 2'b01);
    add(32'h20c, 5'b00100, 32'h0,         3'b110, 32'h20c, NOP,           32'h0,   2'b00);
    add(32'h20c, 5'b10000, 32'h0,         3'b000, 32'h0,   NOP,           32'h0,   2'b00);
    add(32'h400, 5'b00000, 32'h0,         3'b010, 32'h0,   NOP,           32'h0,   2'b00);
    add(32'h400, 5'b00010, 32'hdead_beef, 3'b010, 32'h0,   NOP,           32'h0,   2'b00);
    add(32'h400, 5'b00000, 32'h0,         3'b110, 32'h400, NOP,           32'h0,   2'b00);
    add(32'h400, 5'b00100, 32'h0,         3'b110, 32'h400, NOP,           32'h0,   2'b00);
    add(32'h400, 5'b00010, 32'h0000_0033, 3'b000, 32'h0,   NOP,           32'h0,   2'b00);
    add(32'h404, 5'b00000, 32'h0,         3'b111, 32'h404, 32'h0000_0033, 32'h400, 2'b00);
    add(32'h404, 5'b10100, 32'h0,         3'b100, 32'h404, NOP,           32'h0,   2'b00);
    add(32'h500, 5'b00000, 32'h0,         3'b010, 32'h0,   NOP,           32'h0,   2'b00);
    add(32'h500, 5'b00010, 32'hcafe_f00d, 3'b010, 32'h0,   NOP,           32'h0,   2'b00);
    add(32'h500, 5'b00000, 32'h0,         3'b110, 32'h500, NOP,           32'h0,   2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge clk);
      pc                  = vecs[i].pc;
      flush               = vecs[i].ctl[4];
      id_stall            = vecs[i].ctl[3];
      imem_bus.imem_gnt   = vecs[i].ctl[2];
      imem_bus.imem_rvalid = vecs[i].ctl[1];
      imem_bus.imem_err   = vecs[i].ctl[0];
      imem_bus.imem_rdata = vecs[i].rd;
      #1;
      chk1($sformatf("vec%0d_req", i), imem_bus.imem_req, vecs[i].ec[2]);
      chk32($sformatf("vec%0d_addr", i), imem_bus.imem_addr, vecs[i].ea);
      chk1($sformatf("vec%0d_fstall", i), fetch_stall, vecs[i].ec[1]);
      chk1($sformatf("vec%0d_valid", i), if_valid, vecs[i].ec[0]);
      if (vecs[i].ec[0]) begin
        chk32($sformatf("vec%0d_instr", i), if_instr, vecs[i].ei);
        chk32($sformatf("vec%0d_ifpc", i), if_pc, vecs[i].ep);
        chk1($sformatf("vec%0d_fault", i), if_exc_fault, vecs[i].ef[1]);
        chk1($sformatf("vec%0d_mis", i), if_exc_misaligned, vecs[i].ef[0]);
      end
      if (i >= 20) chk1($sformatf("vec%0d_no_killed_data", i), if_instr === 32'hdead_beef, 1'b0);
    end

    // Asynchronous reset while WAITing, then a late response
    @(negedge clk);
    drive_idle();
    pc = 32'h500; imem_bus.imem_gnt = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    @(negedge clk);
    imem_bus.imem_gnt = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'hbadc_0de5;
    #1;
    chk1("late_idle_fstall", fetch_stall, 1'b1);
    chk1("late_idle_req", imem_bus.imem_req, 1'b0);
    @(negedge clk);
    #1;
    chk1("late_req_req", imem_bus.imem_req, 1'b1);
    chk32("late_req_addr", imem_bus.imem_addr, 32'h500);
    @(negedge clk);
    imem_bus.imem_rvalid = 1'b0;
    #1;
    chk1("late_dropped_valid", if_valid, 1'b0);
    chk1("late_still_req", imem_bus.imem_req, 1'b1);
    chk32("late_instr_nop", if_instr, NOP);

    // Randomized run; the bench plays the PC register and the memory
    @(negedge clk);
    rst = 1'b1; drive_idle();
    pc_reg = 32'h200; pc = pc_reg;
    ob_busy = 1'b0; ob_live = 1'b0; ob_addr = 32'h0; ob_dly = 0;
    sl_v = 1'b0; sl_pc = 32'h0; sl_instr = NOP; sl_flt = 1'b0;
    chain_v = 1'b0; chain_pc = 32'h0; pend_chk = 1'b0; pend_addr = 32'h0;
    consumed = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc != 0) @(negedge clk);
      chk1("rnd_valid", if_valid, sl_v);
      if (sl_v) begin
        chk32("rnd_ifpc", if_pc, sl_pc);
        chk32("rnd_instr", if_instr, sl_instr);
        chk1("rnd_fault", if_exc_fault, sl_flt);
        chk1("rnd_mis", if_exc_misaligned, 1'b0);
      end
      pc       = pc_reg;
      id_stall = ($urandom_range(3) == 0);
      flush    = ($urandom_range(31) == 0);
      imem_bus.imem_gnt = ($urandom_range(2) != 0);
      rv = ob_busy && (ob_dly == 0);
      imem_bus.imem_rvalid = rv;
      imem_bus.imem_rdata  = rv ? mem_word(ob_addr) : $urandom;
      imem_bus.imem_err    = rv && ($urandom_range(7) == 0);
      #1;
      if (flush) chk1("rnd_flush_fstall", fetch_stall, 1'b0);
      if (pend_chk) begin
        chk1("rnd_req_hold", imem_bus.imem_req, 1'b1);
        chk32("rnd_addr_hold", imem_bus.imem_addr, pend_addr);
      end
      if (ob_busy) chk1("rnd_req_while_busy", imem_bus.imem_req, 1'b0);
      if (imem_bus.imem_req) chk32("rnd_addr", imem_bus.imem_addr, pc_reg);
      req_s = imem_bus.imem_req; fs_s = fetch_stall; ipc_s = if_pc;
      addr_s = imem_bus.imem_addr;
      @(posedge clk);
      if (flush) begin
        sl_v = 1'b0; chain_v = 1'b0; ob_live = 1'b0;
      end else begin
        if (sl_v && !id_stall) begin
          consumed++;
          if (chain_v) chk32("rnd_pc_seq", ipc_s, chain_pc + 32'd4);
          chain_v = 1'b1; chain_pc = ipc_s; sl_v = 1'b0;
        end
        if (rv && ob_live) begin
          if (sl_v) chain_v = 1'b0;  // unconsumed instruction overwritten
          sl_v = 1'b1; sl_pc = ob_addr; sl_flt = imem_bus.imem_err;
          sl_instr = imem_bus.imem_err ? NOP : mem_word(ob_addr);
        end
      end
      if (rv) ob_busy = 1'b0;
      else if (ob_busy) ob_dly--;
      if (req_s && imem_bus.imem_gnt) begin
        ob_busy = 1'b1; ob_live = !flush; ob_addr = pc_reg; ob_dly = $urandom_range(3);
      end
      pend_chk  = req_s && !imem_bus.imem_gnt && !flush;
      pend_addr = addr_s;
      if (flush) pc_reg = 32'h400 + ($urandom_range(255) << 2);
      else if (!fs_s) pc_reg = pc_reg + 32'd4;
    end
    chk1("rnd_progress", consumed > 150, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
